// File: rtl/pois_src_pkg.sv
// Shared definitions for the Poisson stimulus source: FSM encoding, taus88
// mask/shift constants and the minimum non-degenerate seed per state word.
package pois_src_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // taus88 component k: s' = ((s & MASKk) << PKk) ^ (((s << QKk) ^ s) >> SKk)
    localparam logic [31:0] MASK1 = 32'hFFFF_FFFE;
    localparam logic [31:0] MASK2 = 32'hFFFF_FFF8;
    localparam logic [31:0] MASK3 = 32'hFFFF_FFF0;

    localparam int P1 = 12;
    localparam int Q1 = 13;
    localparam int S1 = 19;
    localparam int P2 = 4;
    localparam int Q2 = 2;
    localparam int S2 = 25;
    localparam int P3 = 17;
    localparam int Q3 = 3;
    localparam int S3 = 11;

    localparam logic [31:0] MIN_S1 = 32'd2;
    localparam logic [31:0] MIN_S2 = 32'd8;
    localparam logic [31:0] MIN_S3 = 32'd16;

    function automatic logic [31:0] clamp_seed(input logic [31:0] seed,
                                               input logic [31:0] min_val);
        return (seed < min_val) ? min_val : seed;
    endfunction

endpackage

// File: rtl/pois_src_taus.sv
// Combinational taus88 step: advances all three state words once and
// produces the combined uniform word from the stepped state.
module taus88_step
    import pois_src_pkg::*;
(
    input  logic [31:0] s1,
    input  logic [31:0] s2,
    input  logic [31:0] s3,
    output logic [31:0] n1,
    output logic [31:0] n2,
    output logic [31:0] n3,
    output logic [31:0] out
);

    assign n1  = ((s1 & MASK1) << P1) ^ (((s1 << Q1) ^ s1) >> S1);
    assign n2  = ((s2 & MASK2) << P2) ^ (((s2 << Q2) ^ s2) >> S2);
    assign n3  = ((s3 & MASK3) << P3) ^ (((s3 << Q3) ^ s3) >> S3);
    assign out = n1 ^ n2 ^ n3;

endmodule

// File: rtl/pois_src.sv
// Stimulus source for the Poisson sampler: seedable taus88 generator with a
// warm-up discard phase, emitting one {VALID, LAMBDA, RAND} beat per request.
module pois_src
    import pois_src_pkg::*;
#(
    parameter int DELAY  = 1,
    parameter int WARMUP = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SEED_VALID,
    input  logic [1:0]  SEED_SEL,
    input  logic [31:0] SEED,
    input  logic        START,
    input  logic        LAMBDA_VALID,
    input  logic [31:0] LAMBDA_IN,
    output logic        READY,
    output logic        VALID,
    output logic [31:0] LAMBDA,
    output logic [31:0] RAND
);

    if (WARMUP < 0 || WARMUP > 255 || DELAY < 0) begin : g_param_check
        $error("pois_src: WARMUP must be 0..255 and DELAY non-negative");
    end

    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [31:0] s1_q, s2_q, s3_q;
    logic [31:0] n1, n2, n3, step_out;
    logic        seed_wr, accept, step_en;

    taus88_step u_step (
        .s1  (s1_q),
        .s2  (s2_q),
        .s3  (s3_q),
        .n1  (n1),
        .n2  (n2),
        .n3  (n3),
        .out (step_out)
    );

    // READY mirrors "state is RUN", so it doubles as the accept qualifier.
    assign seed_wr = SEED_VALID && (SEED_SEL != 2'd3);
    assign accept  = READY && LAMBDA_VALID && !seed_wr;
    assign step_en = (state_q == ST_WARMUP) || accept;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (START) state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            ST_WARMUP: if (cnt_q == WARM_LAST) state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
        if (seed_wr) state_d = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            READY   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            READY   <= (state_d == ST_RUN);
            if (seed_wr || state_q != ST_WARMUP) cnt_q <= 8'd0;
            else                                 cnt_q <= cnt_q + 8'd1;
        end
    end

    // A seed write takes priority over any step in the same cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1_q <= MIN_S1;
            s2_q <= MIN_S2;
            s3_q <= MIN_S3;
        end else if (seed_wr) begin
            unique case (SEED_SEL)
                2'd0:    s1_q <= clamp_seed(SEED, MIN_S1);
                2'd1:    s2_q <= clamp_seed(SEED, MIN_S2);
                default: s3_q <= clamp_seed(SEED, MIN_S3);
            endcase
        end else if (step_en) begin
            s1_q <= n1;
            s2_q <= n2;
            s3_q <= n3;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            VALID  <= 1'b0;
            LAMBDA <= 32'd0;
            RAND   <= 32'd0;
        end else begin
            VALID <= accept;
            if (accept) begin
                LAMBDA <= LAMBDA_IN;
                RAND   <= step_out;
            end
        end
    end

endmodule

// File: tb/tb_pois_src.sv
// Directed self-checking bench for pois_src: WARMUP=0 instance for the main
// scenarios and a WARMUP=2 instance for the warm-up timing scenario.
module tb_pois_src;

    logic        clk;
    logic        rst_n;

    logic        seed_valid, start, lambda_valid;
    logic [1:0]  seed_sel;
    logic [31:0] seed, lambda_in;
    logic        ready, valid;
    logic [31:0] lambda, rand_w;

    logic        b_start, b_lv;
    logic [31:0] b_lambda_in;
    logic        b_ready, b_valid;
    logic [31:0] b_lambda, b_rand;

    int n_checks = 0;
    int n_errors = 0;

    pois_src #(.DELAY(1), .WARMUP(0)) dut0 (
        .CLK          (clk),
        .RESET        (rst_n),
        .SEED_VALID   (seed_valid),
        .SEED_SEL     (seed_sel),
        .SEED         (seed),
        .START        (start),
        .LAMBDA_VALID (lambda_valid),
        .LAMBDA_IN    (lambda_in),
        .READY        (ready),
        .VALID        (valid),
        .LAMBDA       (lambda),
        .RAND         (rand_w)
    );

    pois_src #(.DELAY(1), .WARMUP(2)) dut2 (
        .CLK          (clk),
        .RESET        (rst_n),
        .SEED_VALID   (1'b0),
        .SEED_SEL     (2'd3),
        .SEED         (32'd0),
        .START        (b_start),
        .LAMBDA_VALID (b_lv),
        .LAMBDA_IN    (b_lambda_in),
        .READY        (b_ready),
        .VALID        (b_valid),
        .LAMBDA       (b_lambda),
        .RAND         (b_rand)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Hand-computed taus88 outputs from the reset seeds 2/8/16.
    localparam logic [31:0] R1 = 32'h0020_2080;
    localparam logic [31:0] R2 = 32'h0200_2C80;
    localparam logic [31:0] R3 = 32'h4808_8062;
    localparam logic [31:0] ONE = 32'h3F80_0000;

    initial begin
        rst_n = 1'b1;
        seed_valid = 1'b0; seed_sel = 2'd3; seed = 32'd0;
        start = 1'b0; lambda_valid = 1'b0; lambda_in = 32'd0;
        b_start = 1'b0; b_lv = 1'b0; b_lambda_in = 32'd0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_ready",  {31'd0, ready},  32'd0);
        check("rst_valid",  {31'd0, valid},  32'd0);
        check("rst_lambda", lambda, 32'd0);
        check("rst_rand",   rand_w, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // WARMUP=2: READY three cycles after the START cycle, requests before then dropped
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_lv = 1'b1; b_lambda_in = 32'h4120_0000;
        check("w2_ready_c1", {31'd0, b_ready}, 32'd0);
        tick();
        check("w2_ready_c2", {31'd0, b_ready}, 32'd0);
        check("w2_valid_c2", {31'd0, b_valid}, 32'd0);
        tick();
        check("w2_ready_c3", {31'd0, b_ready}, 32'd1);
        check("w2_valid_c3", {31'd0, b_valid}, 32'd0);
        tick();
        check("w2_valid",  {31'd0, b_valid}, 32'd1);
        check("w2_rand",   b_rand,   R3);
        check("w2_lambda", b_lambda, 32'h4120_0000);
        b_lv = 1'b0;
        tick();
        check("w2_valid_off", {31'd0, b_valid}, 32'd0);

        // WARMUP=0 basic stream
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s1_ready", {31'd0, ready}, 32'd1);
        check("s1_valid_idle", {31'd0, valid}, 32'd0);
        lambda_valid = 1'b1; lambda_in = ONE;
        tick();
        check("s1_valid_a",  {31'd0, valid}, 32'd1);
        check("s1_rand_a",   rand_w, R1);
        check("s1_lambda_a", lambda, ONE);
        tick();
        check("s1_valid_b",  {31'd0, valid}, 32'd1);
        check("s1_rand_b",   rand_w, R2);
        check("s1_lambda_b", lambda, ONE);
        lambda_valid = 1'b0;
        tick();
        check("s1_valid_off", {31'd0, valid}, 32'd0);
        check("s1_rand_hold", rand_w, R2);

        // Seeds below minimum clamp back to 2/8/16
        seed_valid = 1'b1; seed_sel = 2'd0; seed = 32'd0;
        tick();
        check("seed_ready_drop", {31'd0, ready}, 32'd0);
        seed_sel = 2'd1; seed = 32'd3;
        tick();
        seed_sel = 2'd2; seed = 32'd5;
        tick();
        seed_valid = 1'b0;

        // Request in IDLE dropped
        lambda_valid = 1'b1; lambda_in = 32'h4000_0000;
        tick();
        check("idle_valid",  {31'd0, valid}, 32'd0);
        check("idle_lambda", lambda, ONE);
        lambda_valid = 1'b0;

        // SEED_SEL=3 is a no-op, so START still takes effect
        seed_valid = 1'b1; seed_sel = 2'd3; seed = 32'hDEAD_BEEF; start = 1'b1;
        tick();
        seed_valid = 1'b0; start = 1'b0;
        check("nop_seed_ready", {31'd0, ready}, 32'd1);
        lambda_valid = 1'b1; lambda_in = 32'h4049_0FDB;
        tick();
        check("cl_rand_a",   rand_w, R1);
        check("cl_lambda_a", lambda, 32'h4049_0FDB);
        tick();
        check("cl_rand_b", rand_w, R2);
        tick();
        check("cl_rand_c", rand_w, R3);

        // Seed and request together in RUN: seed wins
        seed_valid = 1'b1; seed_sel = 2'd1; seed = 32'd8;
        tick();
        seed_valid = 1'b0;
        check("col_valid", {31'd0, valid}, 32'd0);
        check("col_ready", {31'd0, ready}, 32'd0);
        check("col_rand_hold", rand_w, R3);
        tick();
        check("col_idle_valid", {31'd0, valid}, 32'd0);

        // Reset mid-burst
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("burst_valid", {31'd0, valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid",  {31'd0, valid}, 32'd0);
        check("mrst_ready",  {31'd0, ready}, 32'd0);
        check("mrst_lambda", lambda, 32'd0);
        check("mrst_rand",   rand_w, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, ready}, 32'd0);
        check("post_rst_valid", {31'd0, valid}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_ready", {31'd0, ready}, 32'd1);
        check("restart_valid", {31'd0, valid}, 32'd0);
        tick();
        check("restart_valid_a", {31'd0, valid}, 32'd1);
        check("restart_rand_a",  rand_w, R1);
        lambda_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
